// File: rtl/dino_score_pkg.sv
// Shared types and constants for the dino score counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dino_score_pkg;

    localparam int DIGITS_DEFAULT = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Number of decimal digits below a power-of-ten milestone (100 -> 2).
    function automatic int log10_int(input int v);
        int n;
        int r;
        n = 0;
        r = v;
        for (int i = 0; i < 9; i++) begin
            if (r >= 10) begin
                r = r / 10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/dino_score_counter_bcd_digit.sv
// One BCD decade: increments on inc, wraps 9 -> 0 and raises carry.
// Latency: digit updates one cycle after inc/clr; carry is combinational.
// Backpressure: none.
module bcd_digit
    import dino_score_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc) begin
            digit_d = (digit_q == BCD_NINE) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == BCD_NINE);

endmodule

// File: rtl/dino_score_counter.sv
// Score counter: counts score_tick rising edges as packed BCD during play; hi-score kept under DINO_SCORE_HISCORE_EN.
// Latency: score_bcd/score_upd/milestone change one cycle after the sampled edge.
// Backpressure: none; every qualifying edge is counted or dropped at saturation.
module dino_score_counter
    import dino_score_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEFAULT,
    parameter int MILESTONE = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gameon,
    input  logic                  score_tick,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   hi_bcd,
    output logic                  score_upd,
    output logic                  milestone,
    output logic                  saturated
);

    localparam int MS_DIGITS = log10_int(MILESTONE);

    state_e state_q;
    state_e state_d;
    logic   tick_q;
    logic   upd_q;
    logic   upd_d;
    logic   ms_q;
    logic   ms_d;
    logic   sat_q;
    logic   sat_d;
    logic   tick_rise;
    logic   cnt_en;
    logic   clr;
    logic   all_nines;
    logic   carry_unused;
    logic [DIGITS-1:0] nine_v;
    wire  [DIGITS:0]   inc_v;

    assign tick_rise = score_tick & ~tick_q;
    assign inc_v[0]  = cnt_en;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (inc_v[k]),
            .digit (score_bcd[4*k +: 4]),
            .carry (inc_v[k+1])
        );
        assign nine_v[k] = (score_bcd[4*k +: 4] == BCD_NINE);
    end

    assign all_nines = &nine_v;
    // Carry out of the last decade below the milestone means the new value is a multiple of it.
    assign ms_d = inc_v[MS_DIGITS];
    // Top-decade carry never fires: counting is blocked at all-nines.
    assign carry_unused = inc_v[DIGITS];

    always_comb begin
        state_d = state_q;
        sat_d   = sat_q;
        clr     = 1'b0;
        cnt_en  = 1'b0;
        upd_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (gameon) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (!gameon) begin
                    state_d = ST_OVER;
                end else if (tick_rise) begin
                    if (all_nines) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        upd_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= 1'b0;
            upd_q   <= 1'b0;
            ms_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= score_tick;
            upd_q   <= upd_d;
            ms_q    <= ms_d;
            sat_q   <= sat_d;
        end
    end

`ifdef DINO_SCORE_HISCORE_EN
    logic [4*DIGITS-1:0] hi_q;
    logic [4*DIGITS-1:0] hi_d;

    // Packed BCD orders the same as binary, so a plain compare suffices.
    always_comb begin
        hi_d = hi_q;
        if ((state_q == ST_RUN) && !gameon && (score_bcd > hi_q)) begin
            hi_d = score_bcd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign hi_bcd = hi_q;
`else
    assign hi_bcd = '0;
`endif

    assign score_upd = upd_q;
    assign milestone = ms_q;
    assign saturated = sat_q;

endmodule
